// File: rtl/serial_shift_unit.sv
// ---------------------------------------------------------------------------
// serial_shift_unit
//
// Multi-cycle serial shifter. An operand is captured on start. A working
// register then moves one bit per clock until the effective shift count is
// used up. The result is presented on dout with a one-cycle done pulse.
//
// Configuration macro:
//   SHIFT_ROTATE_EN  - when defined, mode 2'b11 rotates right by
//                      (shamt mod WIDTH). When undefined, mode 2'b11 is an
//                      alias of arithmetic right (2'b01) and no rotate path
//                      exists in the logic.
//
// Parameters:
//   WIDTH    - data width in bits (2..64)
//   SHAMT_W  - shift-amount width, wide enough for shamt == WIDTH
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while idle
//   mode   in   00 lsr, 01 asr, 10 lsl, 11 ror (or asr, see above)
//   shamt  in   unsigned shift amount
//   din    in   operand
//   busy   out  high while shifting
//   done   out  one-cycle pulse, dout valid
//   dout   out  registered result, held until the next done
// ---------------------------------------------------------------------------
module serial_shift_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   din,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHAMT_W-1:0] WIDTH_C = SHAMT_W'(WIDTH);
  localparam logic [SHAMT_W-1:0] ONE_C   = SHAMT_W'(1);

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0]         op;

  logic [SHAMT_W-1:0] eff_cnt;
  logic [1:0]         cap_op;
  logic [WIDTH-1:0]   step;

  // Effective count and the operation actually latched at capture time.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    eff_cnt = (shamt > WIDTH_C) ? WIDTH_C : shamt;
    cap_op  = mode;
`ifdef SHIFT_ROTATE_EN
    if (mode == 2'b11) begin
      // A rotate by WIDTH is the identity, so only the remainder matters.
      eff_cnt = shamt % WIDTH_C;
    end
`else
    // Without rotate support, mode 11 is stored as arithmetic right so the
    // shift datapath never sees the 11 encoding.
    if (mode == 2'b11) begin
      cap_op = 2'b01;
    end
`endif
  end

  // One-bit step of the working register.
  always_comb begin
    step = work;
    case (op)
      2'b00:   step = {1'b0, work[WIDTH-1:1]};
      2'b01:   step = {work[WIDTH-1], work[WIDTH-1:1]};
      2'b10:   step = {work[WIDTH-2:0], 1'b0};
`ifdef SHIFT_ROTATE_EN
      default: step = {work[0], work[WIDTH-1:1]};
`else
      default: step = {work[WIDTH-1], work[WIDTH-1:1]};
`endif
    endcase
  end

  // Control FSM. busy, done and dout are all registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register, including the datapath, is reset. An abort
      // must leave no stale operand or count behind.
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      dout  <= '0;
      work  <= '0;
      cnt   <= '0;
      op    <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work <= din;
            op   <= cap_op;
            cnt  <= eff_cnt;
            if (eff_cnt == '0) begin
              // Zero-length shift skips SHIFT entirely.
              state <= DONE;
              done  <= 1'b1;
              dout  <= din;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work <= step;
          cnt  <= cnt - ONE_C;
          if (cnt == ONE_C) begin
            // The final step goes straight to dout, so DONE needs no extra cycle.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            dout  <= step;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_serial_shift_unit
//
// Directed testbench for serial_shift_unit with WIDTH=16. Each step drives a
// request and checks the latency to done, the result, busy, and whether dout
// holds afterwards. Expected values are computed by hand. The values for mode
// 11 depend on SHIFT_ROTATE_EN.
// ---------------------------------------------------------------------------
module tb_serial_shift_unit;

  localparam int WIDTH   = 16;
  localparam int SHAMT_W = 5;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [1:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   din;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   dout;

  int checks   = 0;
  int failures = 0;

  serial_shift_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .shamt (shamt),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Waits for done, bounded, starting one cycle after the sampling edge.
  // The latency returned counts cycles from that edge. A value above the
  // bound means done never arrived.
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat <= 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One full transaction. After capture the inputs are scrambled, so the
  // result must come from the captured operand only.
  task automatic run(input string tag, input logic [1:0] m,
                     input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s,
                     input logic [WIDTH-1:0] exp_dout, input int exp_lat);
    int lat;
    mode  = m;
    din   = d;
    shamt = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    din   = ~d;
    mode  = ~m;
    shamt = '0;
    check({tag, "_busy"}, 64'(busy), 64'(exp_lat > 1));
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_dout"}, 64'(dout), 64'(exp_dout));
    check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_hold"}, 64'(dout), 64'(exp_dout));
  endtask

  initial begin
    int lat;
    int seen_done;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'b00;
    shamt = '0;
    din   = '0;
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dout", 64'(dout), 64'd0);
    rst_n = 1'b1;
    #2;

    // The first start is taken on the first edge with reset released.
    run("asr_1",        2'b01, 16'h8001, 5'd1,  16'hC000, 2);
    run("lsr_4",        2'b00, 16'h8001, 5'd4,  16'h0800, 5);
    run("lsl_15",       2'b10, 16'h0001, 5'd15, 16'h8000, 16);
    run("asr_clamp",    2'b01, 16'h8000, 5'd20, 16'hFFFF, 17);
    run("asr_zero",     2'b01, 16'h1234, 5'd0,  16'h1234, 1);
    run("lsr_full",     2'b00, 16'hFFFF, 5'd16, 16'h0000, 17);
    run("lsl_clamp",    2'b10, 16'h00FF, 5'd20, 16'h0000, 17);
    run("asr_pos",      2'b01, 16'h7FF0, 5'd4,  16'h07FF, 5);
`ifdef SHIFT_ROTATE_EN
    run("m11_17",       2'b11, 16'h0001, 5'd17, 16'h8000, 2);
    run("m11_4",        2'b11, 16'h1234, 5'd4,  16'h4123, 5);
`else
    run("m11_17",       2'b11, 16'h0001, 5'd17, 16'h0000, 17);
    run("m11_4",        2'b11, 16'h1234, 5'd4,  16'h0123, 5);
`endif

    // A start while busy is ignored. It carries a different operand.
    mode = 2'b00; din = 16'h8001; shamt = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    mode = 2'b10; din = 16'hFFFF; shamt = 5'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    wait_done(lat);
    check("busy_start_lat", 64'(lat + 2), 64'd5);
    check("busy_start_dout", 64'(dout), 64'h0800);

    // A start held through the DONE cycle is taken on the first IDLE cycle.
    mode = 2'b01; din = 16'hA5A5; shamt = 5'd0; start = 1'b1;
    @(posedge clk); #1;
    check("b2b_idle_done", 64'(done), 64'd0);
    check("b2b_idle_dout", 64'(dout), 64'h0800);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_accept_done", 64'(done), 64'd1);
    check("b2b_accept_dout", 64'(dout), 64'hA5A5);
    @(posedge clk); #1;

    // Reset in the middle of a shamt=10 operation aborts it at once.
    mode = 2'b00; din = 16'hFFFF; shamt = 5'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk); #2;
    check("abort_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_dout", 64'(dout), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    #3;
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);

    // The unit still works normally after the abort.
    run("post_abort",   2'b10, 16'h0003, 5'd2,  16'h000C, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
